// File: rtl/sm2_red_512to256_ir_if.sv
// Request/response bundle between the 512-bit product source and the SM2 reducer.
// The reducer takes the slave side; the product source or testbench takes the master side.
interface sm2_red_512to256_ir_if;
  logic         red_vld_i;
  logic [511:0] red_a_i;
  logic         red_busy_o;
  logic         red_fin_o;
  logic [255:0] red_r_o;

  modport slave (
    input  red_vld_i,
    input  red_a_i,
    output red_busy_o,
    output red_fin_o,
    output red_r_o
  );

  modport master (
    output red_vld_i,
    output red_a_i,
    input  red_busy_o,
    input  red_fin_o,
    input  red_r_o
  );
endinterface

// File: rtl/sm2_red_512to256_ir.sv
// Iterative SM2 reducer: folds the upper 256 bits back into the lower half until the value fits,
// then finishes with a single conditional subtraction of p.
module sm2_red_512to256_ir (
  input  logic                 clk,
  input  logic                 rst,
  sm2_red_512to256_ir_if.slave bus
);

  localparam logic [255:0] P_MOD =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_FOLD = 4'b0010,
    S_SUB  = 4'b0100,
    S_FIN  = 4'b1000
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [511:0] r_x;
  logic [511:0] w_x_next;
  logic [255:0] r_r;
  logic [255:0] w_r_next;

  logic [255:0] w_hi;
  logic [255:0] w_lo;
  logic [511:0] w_hi_ext;
  logic [511:0] w_fold;
  logic         w_hi_zero;
  logic         w_ge_p;
  logic [255:0] w_lo_minus_p;

  assign w_hi      = r_x[511:256];
  assign w_lo      = r_x[255:0];
  assign w_hi_ext  = {256'd0, w_hi};
  assign w_hi_zero = (w_hi == 256'd0);

  // 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p). The true result is never negative and stays
  // below 2^482, so evaluating modulo 2^512 gives the exact value.
  assign w_fold = {256'd0, w_lo}
                + (w_hi_ext << 224)
                + (w_hi_ext << 96)
                + w_hi_ext
                - (w_hi_ext << 64);

  assign w_ge_p       = (w_lo >= P_MOD);
  assign w_lo_minus_p = w_lo - P_MOD;

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_r_next     = r_r;
    case (r_state)
      S_IDLE: begin
        if (bus.red_vld_i) begin
          w_x_next     = bus.red_a_i;
          w_state_next = S_FOLD;
        end
      end
      S_FOLD: begin
        if (w_hi_zero) begin
          w_state_next = S_SUB;
        end else begin
          w_x_next = w_fold;
        end
      end
      S_SUB: begin
        // x < 2^256 < 2p here, so one subtraction always lands in [0, p).
        w_r_next     = w_ge_p ? w_lo_minus_p : w_lo;
        w_state_next = S_FIN;
      end
      S_FIN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= 512'd0;
      r_r     <= 256'd0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_r     <= w_r_next;
    end
  end

  assign bus.red_busy_o = (r_state != S_IDLE);
  assign bus.red_fin_o  = (r_state == S_FIN);
  assign bus.red_r_o    = r_r;

endmodule

// File: tb/tb_sm2_red_512to256_ir.sv
// Directed bench for the SM2 512->256 reducer: vector table plus protocol corner-case sequences.
module tb_sm2_red_512to256_ir;

  localparam logic [255:0] P_MOD =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] C_ONE_FOLD =
    256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;
  localparam logic [255:0] C_ALL_ONES_256 =
    256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000000;

  typedef struct {
    string        name;
    logic [511:0] a;
    logic [255:0] r;
    int           lat;   // 0: only the upper bound of 13 is checked
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sm2_red_512to256_ir_if bus ();

  sm2_red_512to256_ir dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] golden(input logic [511:0] a);
    logic [511:0] p512;
    logic [511:0] m;
    p512 = {256'd0, P_MOD};
    m    = a % p512;
    return m[255:0];
  endfunction

  // Called #1 after a clock edge with the DUT idle; returns #1 after an edge with the DUT idle.
  task automatic run_op(input string name, input logic [511:0] a, input logic [255:0] exp_r,
                        input int exp_lat, input bit disturb);
    int cyc;
    int busy_cnt;
    bit got;
    chk({name, " idle_before"}, {511'd0, bus.red_busy_o}, 512'd0);
    bus.red_vld_i = 1'b1;
    bus.red_a_i   = a;
    @(posedge clk);
    #1;
    bus.red_vld_i = 1'b0;
    if (disturb) bus.red_a_i = ~a;
    cyc      = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (cyc < 20) begin
      cyc++;
      if (bus.red_busy_o) busy_cnt++;
      if (bus.red_fin_o) begin
        got = 1'b1;
        break;
      end
      if (disturb) begin
        bus.red_vld_i = 1'b1;
        bus.red_a_i   = rnd512();
      end
      @(posedge clk);
      #1;
    end
    bus.red_vld_i = 1'b0;
    chk({name, " fin_seen"}, {511'd0, got}, {511'd0, 1'b1});
    if (exp_lat > 0) chk({name, " latency"}, cyc, exp_lat);
    else             chk({name, " latency<=13"}, {511'd0, (cyc <= 13)}, {511'd0, 1'b1});
    chk({name, " busy_cycles"}, busy_cnt, cyc);
    chk({name, " result"}, {256'd0, bus.red_r_o}, {256'd0, exp_r});
    $display("op %s: latency=%0d r=%h", name, cyc, bus.red_r_o);
    @(posedge clk);
    #1;
    chk({name, " fin_one_cycle"}, {511'd0, bus.red_fin_o}, 512'd0);
    chk({name, " idle_after"}, {511'd0, bus.red_busy_o}, 512'd0);
  endtask

  initial begin
    vec_t         vecs[12];
    logic [511:0] p512;
    logic [511:0] pm1w;
    logic [511:0] ones;
    logic [511:0] t;
    int           fins;

    n_cmp = 0;
    n_err = 0;
    p512  = {256'd0, P_MOD};
    pm1w  = p512 - 512'd1;
    ones  = '1;

    vecs[0]  = '{"zero",        512'd0,                   256'd0,               3};
    vecs[1]  = '{"p-1",         pm1w,                     P_MOD - 256'd1,       3};
    vecs[2]  = '{"p",           p512,                     256'd0,               3};
    vecs[3]  = '{"p+5",         p512 + 512'd5,            256'd5,               3};
    vecs[4]  = '{"2^256-1",     {256'd0, {256{1'b1}}},    C_ALL_ONES_256,       3};
    vecs[5]  = '{"2^256",       512'd1 << 256,            C_ONE_FOLD,           4};
    vecs[6]  = '{"2p",          p512 << 1,                256'd0,               0};
    vecs[7]  = '{"(p-1)^2",     pm1w * pm1w,              256'd1,               0};
    vecs[8]  = '{"2^512-1",     ones,                     golden(ones),         0};
    for (int i = 9; i < 12; i++) begin
      t       = rnd512();
      vecs[i] = '{$sformatf("rand%0d", i - 9), t, golden(t), 0};
    end

    rst           = 1'b1;
    bus.red_vld_i = 1'b0;
    bus.red_a_i   = 512'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset busy", {511'd0, bus.red_busy_o}, 512'd0);
    chk("reset fin",  {511'd0, bus.red_fin_o},  512'd0);
    chk("reset r",    {256'd0, bus.red_r_o},    512'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].r, vecs[i].lat, 1'b0);
    end

    // Request held high: accepted only from IDLE, so the pattern repeats every 4 cycles.
    bus.red_vld_i = 1'b1;
    bus.red_a_i   = pm1w;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("held k=%0d fin", k),  {511'd0, bus.red_fin_o},  {511'd0, (k % 4 == 3)});
      chk($sformatf("held k=%0d busy", k), {511'd0, bus.red_busy_o}, {511'd0, (k % 4 != 0)});
    end
    bus.red_vld_i = 1'b0;
    chk("held result", {256'd0, bus.red_r_o}, {256'd0, P_MOD - 256'd1});
    $display("op held-vld: 5 back-to-back operations r=%h", bus.red_r_o);

    // Operand and strobe toggled while busy must not disturb the result.
    run_op("disturb 2^256", 512'd1 << 256, C_ONE_FOLD, 4, 1'b1);
    run_op("disturb 2^512-1", ones, golden(ones), 0, 1'b1);

    // Reset during FOLD aborts cleanly.
    bus.red_vld_i = 1'b1;
    bus.red_a_i   = ones;
    @(posedge clk);
    #1;
    bus.red_vld_i = 1'b0;
    @(posedge clk);
    #1;
    chk("abort busy before rst", {511'd0, bus.red_busy_o}, {511'd0, 1'b1});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", {511'd0, bus.red_busy_o}, 512'd0);
    chk("abort fin",  {511'd0, bus.red_fin_o},  512'd0);
    chk("abort r",    {256'd0, bus.red_r_o},    512'd0);
    fins = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.red_fin_o) fins++;
      @(posedge clk);
      #1;
    end
    chk("abort no fin", fins, 0);
    $display("op abort: reset during FOLD, r=%h", bus.red_r_o);
    run_op("after abort 2^256", 512'd1 << 256, C_ONE_FOLD, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
